// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared op codes and multiply/divide FSM states
package mips_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_e;

endpackage

// File: rtl/mips_negate_cond.sv
// rtl/mips_negate_cond.sv - two's-complement negate when neg_i is set (abs and sign fix-up)
module mips_negate_cond #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic             neg_i,
   output logic [WIDTH-1:0] y_o
);

   assign y_o = neg_i ? (~a_i + {{(WIDTH-1){1'b0}}, 1'b1}) : a_i;

endmodule

// File: rtl/mips_muldiv_seq.sv
// rtl/mips_muldiv_seq.sv - sequential HI/LO multiply/divide unit, one bit per enabled edge
module mips_muldiv_seq
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clock_enable,
   input  logic             start,
   input  op_e              op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e             state_q;
   op_e                op_q;
   logic               sign_a_q, sign_b_q, b_zero_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   opnd_q, hi_q, lo_q;
   logic [2*WIDTH-1:0] prod_q;
   logic               done_q, dz_q;

   logic               is_signed;
   logic [WIDTH-1:0]   mag_a, mag_b, quo_fix, rem_fix;
   logic [2*WIDTH-1:0] prod_fix;

   assign is_signed = (op == OP_MULT) || (op == OP_DIV);

   mips_negate_cond #(.WIDTH(WIDTH)) u_abs_a (
      .a_i(op_a), .neg_i(is_signed & op_a[WIDTH-1]), .y_o(mag_a));
   mips_negate_cond #(.WIDTH(WIDTH)) u_abs_b (
      .a_i(op_b), .neg_i(is_signed & op_b[WIDTH-1]), .y_o(mag_b));
   mips_negate_cond #(.WIDTH(2*WIDTH)) u_fix_prod (
      .a_i(prod_q), .neg_i(sign_a_q ^ sign_b_q), .y_o(prod_fix));
   mips_negate_cond #(.WIDTH(WIDTH)) u_fix_quo (
      .a_i(prod_q[WIDTH-1:0]), .neg_i(sign_a_q ^ sign_b_q), .y_o(quo_fix));
   mips_negate_cond #(.WIDTH(WIDTH)) u_fix_rem (
      .a_i(prod_q[2*WIDTH-1:WIDTH]), .neg_i(sign_a_q), .y_o(rem_fix));

   // prod_q holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV
   logic [WIDTH:0]     add_sum_d, rem_sh_d, diff_d;
   logic               ge_d;
   logic [2*WIDTH-1:0] mul_step_d, div_step_d;

   always_comb begin
      add_sum_d  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (prod_q[0] ? opnd_q : {WIDTH{1'b0}})};
      mul_step_d = {add_sum_d, prod_q[WIDTH-1:1]};
      rem_sh_d   = prod_q[2*WIDTH-1:WIDTH-1];
      ge_d       = rem_sh_d >= {1'b0, opnd_q};
      diff_d     = rem_sh_d - {1'b0, opnd_q};
      div_step_d = ge_d ? {diff_d[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1}
                        : {rem_sh_d[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_MULT;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         b_zero_q <= 1'b0;
         cnt_q    <= '0;
         opnd_q   <= '0;
         prod_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else if (clock_enable) begin
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  case (op)
                     OP_MTHI: hi_q <= op_a;
                     OP_MTLO: lo_q <= op_a;
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        op_q     <= op;
                        sign_a_q <= is_signed & op_a[WIDTH-1];
                        sign_b_q <= is_signed & op_b[WIDTH-1];
                        b_zero_q <= (op_b == '0);
                        cnt_q    <= '0;
                        if (op == OP_MULT || op == OP_MULTU) begin
                           prod_q  <= {{WIDTH{1'b0}}, mag_b};
                           opnd_q  <= mag_a;
                           state_q <= ST_MUL;
                        end else begin
                           prod_q  <= {{WIDTH{1'b0}}, mag_a};
                           opnd_q  <= mag_b;
                           state_q <= ST_DIV;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               prod_q <= mul_step_d;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == LAST) state_q <= ST_FIX;
            end
            ST_DIV: begin
               prod_q <= div_step_d;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == LAST) state_q <= ST_FIX;
            end
            ST_FIX: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b1;
               if (op_q == OP_MULT || op_q == OP_MULTU) begin
                  {hi_q, lo_q} <= prod_fix;
               end else begin
                  // divide by zero: remainder path already reproduces op_a, quotient is forced
                  hi_q <= rem_fix;
                  lo_q <= b_zero_q ? {WIDTH{1'b1}} : quo_fix;
                  dz_q <= b_zero_q;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mips_muldiv_seq.sv
// tb/tb_mips_muldiv_seq.sv - randomized self-checking bench against an arithmetic reference model
module tb_mips_muldiv_seq;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset, clock_enable, start;
   op_e         op;
   logic [31:0] op_a, op_b;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_hi, model_lo;

   mips_muldiv_seq #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .clock_enable(clock_enable), .start(start),
      .op(op), .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
      .div_zero(div_zero), .hi(hi), .lo(lo));

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic void model(input op_e o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output logic dz);
      logic [63:0] p;
      longint sa, sb, q, r;
      dz = 1'b0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
         OP_MULT:  begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
         OP_DIVU, OP_DIV: begin
            if (b == 32'd0) begin
               h = a; l = 32'hFFFF_FFFF; dz = 1'b1;
            end else if (o == OP_DIVU) begin
               h = a % b; l = a / b;
            end else begin
               q = sa / sb; r = sa % sb;
               h = 32'(r); l = 32'(q);
            end
         end
         default: begin h = model_hi; l = model_lo; end
      endcase
   endfunction

   task automatic run_op(input op_e o, input logic [31:0] a, input logic [31:0] b,
                         input int stall_len, input bit inject_mthi);
      logic [31:0] eh, el;
      logic        edz;
      int          clocks;
      bit          busy_ok;
      model(o, a, b, eh, el, edz);
      @(negedge clk);
      op = o; op_a = a; op_b = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      clocks = 1;
      busy_ok = busy;
      while (!done && clocks < 200) begin
         if (inject_mthi && clocks == 5) begin
            op = OP_MTHI; op_a = $urandom; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         clock_enable = !(stall_len > 0 && clocks >= 10 && clocks < 10 + stall_len);
         @(negedge clk);
         clocks++;
         if (!done && !busy) busy_ok = 1'b0;
      end
      start = 1'b0;
      clock_enable = 1'b1;
      check_val("latency", 64'(clocks), 64'(34 + stall_len));
      check_val("busy_during", 64'(busy_ok), 64'd1);
      check_val("busy_at_done", 64'(busy), 64'd0);
      check_val("hi", 64'(hi), 64'(eh));
      check_val("lo", 64'(lo), 64'(el));
      check_val("div_zero", 64'(div_zero), 64'(edz));
      model_hi = eh;
      model_lo = el;
      @(negedge clk);
      check_val("done_pulse", 64'(done), 64'd0);
      check_val("hi_hold", 64'(hi), 64'(model_hi));
   endtask

   initial begin
      bit saw_done;
      logic [31:0] ra, rb;
      op_e ro;
      reset = 1'b1; clock_enable = 1'b0; start = 1'b0; op = OP_MULT;
      op_a = '0; op_b = '0;
      model_hi = '0; model_lo = '0;
      repeat (2) @(negedge clk);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_done", 64'(done), 64'd0);
      check_val("rst_dz", 64'(div_zero), 64'd0);
      check_val("rst_hi", 64'(hi), 64'd0);
      check_val("rst_lo", 64'(lo), 64'd0);
      reset = 1'b0; clock_enable = 1'b1;

      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
      check_val("multu_max_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, 1'b0);
      check_val("mult_lo", 64'(lo), 64'h0000_0000_FFFF_FFF1);
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
      check_val("div_neg_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
      run_op(OP_DIVU, 32'd7, 32'd0, 0, 1'b0);
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
      run_op(OP_DIV, 32'h8000_0000, 32'd0, 0, 1'b0);
      run_op(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 5, 1'b0);
      run_op(OP_DIVU, 32'hDEAD_BEEF, 32'h0000_1234, 0, 1'b1);

      // MTLO then MTHI on consecutive edges
      @(negedge clk);
      op = OP_MTLO; op_a = 32'h1234; start = 1'b1;
      @(negedge clk);
      model_lo = 32'h1234;
      check_val("mtlo_lo", 64'(lo), 64'(model_lo));
      check_val("mtlo_busy", 64'(busy), 64'd0);
      op = OP_MTHI; op_a = 32'h5678;
      @(negedge clk);
      start = 1'b0;
      model_hi = 32'h5678;
      check_val("mthi_hi", 64'(hi), 64'(model_hi));
      check_val("mthi_lo", 64'(lo), 64'(model_lo));
      check_val("mthi_done", 64'(done), 64'd0);

      // reset in the middle of a divide
      op = OP_DIV; op_a = 32'd1000; op_b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_hi = '0; model_lo = '0;
      check_val("midrst_busy", 64'(busy), 64'd0);
      check_val("midrst_hi", 64'(hi), 64'd0);
      check_val("midrst_lo", 64'(lo), 64'd0);
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check_val("midrst_no_done", 64'(saw_done), 64'd0);

      // start coinciding with reset is dropped
      reset = 1'b1; start = 1'b1; op = OP_MULT; op_a = 32'd3; op_b = 32'd4;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      check_val("rst_start_busy", 64'(busy), 64'd0);

      for (int i = 0; i < 40; i++) begin
         ro = op_e'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = $urandom_range(1, 15);
            3: rb = -32'($urandom_range(1, 15));
            default: ;
         endcase
         run_op(ro, ra, rb, (i % 10 == 3) ? 3 : 0, (i % 7 == 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_muldiv_seq.md
MIPS_MULDIV_SEQ -- requirements
Module: mips_muldiv_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width; legal values are even and at least 4.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 clock_enable  input  1  when low, all internal state and outputs hold for that edge.
REQ-005 start  input  1  operation request, sampled on an enabled edge.
REQ-006 op  input  3  operation code (MULT, MULTU, DIV, DIVU, MTHI, MTLO), from the shared package.
REQ-007 op_a  input  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO source.
REQ-008 op_b  input  WIDTH  rt operand: multiplier or divisor.
REQ-009 busy  output  1  high while a multiply or divide is in progress.
REQ-010 done  output  1  one-cycle pulse when HI/LO receive a multiply or divide result.
REQ-011 div_zero  output  1  high together with done when the completed divide had op_b == 0.
REQ-012 hi  output  WIDTH  HI register.
REQ-013 lo  output  WIDTH  LO register.

Function
REQ-014 FSM states: IDLE, MUL, DIV, FIX; busy SHALL equal (state != IDLE).
REQ-015 In IDLE, an enabled edge with start=1 SHALL latch operand magnitudes, the operand signs and the op code, clear the iteration counter, and enter MUL or DIV.
REQ-016 MTHI or MTLO with start=1 in IDLE SHALL write op_a to hi or lo on that edge, stay in IDLE, and assert neither busy nor done.
REQ-017 start while busy SHALL be ignored, with no effect on the in-flight operation.
REQ-018 MUL SHALL run shift-add, one multiplier bit per enabled edge, for exactly WIDTH edges, then go to FIX.
REQ-019 DIV SHALL run restoring radix-2 division, one quotient bit per enabled edge, for exactly WIDTH edges, then go to FIX.
REQ-020 FIX (one edge) SHALL apply sign correction, write hi/lo, return to IDLE, and assert done (and div_zero if applicable) for the following cycle only.
REQ-021 Latency: start accepted at edge E0 means hi/lo are updated and done is high after edge E(WIDTH+1), i.e. 34 enabled edges for WIDTH=32; busy falls on the same edge that done rises.
REQ-022 MULTU: {hi,lo} SHALL equal the unsigned 2*WIDTH-bit product.
REQ-023 MULT: {hi,lo} SHALL equal the two's-complement 2*WIDTH-bit product; the result is negated in FIX when the operand signs differ.
REQ-024 DIVU: lo SHALL be the quotient and hi the remainder.
REQ-025 DIV: quotient truncated toward zero, remainder takes the dividend's sign; magnitude arithmetic, corrected in FIX.
REQ-026 Divide by zero (DIV or DIVU): lo SHALL be all ones, hi SHALL be op_a unchanged, and div_zero SHALL be 1; iteration still takes the full latency.
REQ-027 DIV of the most negative value by -1: lo SHALL be the most negative value and hi SHALL be 0 (wrap, no flag).
REQ-028 clock_enable low mid-operation SHALL freeze the counter and datapath; latency counts enabled edges only.
REQ-029 hi/lo SHALL change only on MTHI/MTLO, at FIX, or at reset.

Reset
REQ-030 reset=1 on a rising edge SHALL force IDLE, clear hi, lo and the counter, and drive busy, done and div_zero to 0, regardless of clock_enable.
REQ-031 Reset mid-operation SHALL abandon the operation with no done pulse; start in the same cycle as reset SHALL be ignored.

Structure
REQ-032 The op-code enum and the FSM state enum SHALL live in shared package mips_pkg, which is also used by the CPU decoder.
REQ-033 The sign-magnitude conversion (abs and conditional negate, WIDTH and 2*WIDTH variants) SHALL be a single sub-module, mips_negate_cond.
REQ-034 The CPU SHALL stall MFHI/MFLO while busy=1; this block provides no forwarding.

Verification (WIDTH=32)
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 edges after start; busy high for 34 cycles.
REQ-036 MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=0x00000007, div_zero=1 with done; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 MTLO 0x1234 then MTHI 0x5678 on consecutive edges -> lo=0x1234, hi=0x5678 after each edge; busy and done stay 0; MTHI issued while busy is ignored.
REQ-039 clock_enable low for 5 cycles mid-MULTU -> done arrives 39 clocks after start with the correct product.
REQ-040 Reset asserted at iteration 10 of a DIV -> next cycle busy=0, hi=lo=0, and no done pulse appears.
